sel_reg_wr_alu_decoder: RTL and testbench
=========================================

# sel_reg_wr_alu_decoder

Register-file write-data source selector for the 8-bit core. Chooses, per instruction, whether the value written into the destination register comes from the ALU result or from the decoder's literal/address field, presents it combinationally to the register file, and keeps a registered copy of the last committed write for forwarding and debug. It sits between the ALU/decoder outputs and the register-file write port.

## Interface
- DataWidth, default 8: width of all data paths.
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- literal_adr  input  DataWidth  literal/address value from the decoder.
- result  input  DataWidth  ALU result.
- sel_reg_in_alu_decoder  input  1  source select: 1 = ALU (result), 0 = decoder (literal_adr).
- wr_en  input  1  register-file write strobe for this cycle.
- reg_val  output  DataWidth  value written into the register; combinational.
- reg_zero  output  1  combinational: reg_val is all zeros.
- reg_val_q  output  DataWidth  last committed write value, registered.
- src_alu_q  output  1  source of last committed write: 1 = ALU, 0 = decoder.
- wr_seen_q  output  1  set after the first committed write since reset.
- reg_par  output  1  even parity of reg_val; present only with SEL_REG_WR_PARITY_EN.

## Operation
- reg_val = result when sel_reg_in_alu_decoder = 1, else literal_adr. Pure combinational; no clock dependency.
- X/Z on sel_reg_in_alu_decoder is not a legal input.
- reg_zero = (reg_val == 0).
- On a rising clk edge with wr_en = 1: reg_val_q <= reg_val, src_alu_q <= sel_reg_in_alu_decoder, wr_seen_q <= 1.
- wr_en = 0: all registered outputs hold.
- Source switching and input changes in the same cycle as wr_en: the value captured is the one combinationally selected at the edge.
- No arithmetic; widths are identical on both sources, no extension or truncation.

## Timing
- reg_val, reg_zero, reg_par: zero-cycle latency, settle within the same cycle as any input change.
- reg_val_q, src_alu_q, wr_seen_q: one-cycle latency after the wr_en edge.
- Reset (reset_n low, any time, asynchronous): reg_val_q = 0, src_alu_q = 0, wr_seen_q = 0. Combinational outputs are unaffected by reset and keep following inputs.
- Reset deassertion is synchronized externally; the first capture is allowed on the first edge with reset_n high.
- Reset asserted during a write cycle: the reset wins and the write is lost.

## Configuration
- SEL_REG_WR_PARITY_EN defined: reg_par output exists and equals the XOR of all bits of reg_val, combinational.
- SEL_REG_WR_PARITY_EN not defined: the reg_par port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package: source-select constants SRC_DECODER = 1'b0 and SRC_ALU = 1'b1, and the default data width constant.
- One sub-module, sel_reg_wr_mux: the parameterized 2:1 combinational data mux. The top level holds the zero flag, the optional parity, and the capture registers.

## Test plan
- sel = 1, literal_adr = 0x00, result = 0x00 -> reg_val = 0x00 and reg_zero = 1, one time unit after the inputs are applied.
- sel = 1, result changes to 0x44 -> reg_val = 0x44 and reg_zero = 0, combinationally with no clock edge.
- sel = 0, literal_adr = 0xF3, result = 0x00 -> reg_val = 0xF3; the ALU value is ignored.
- sel = 1, result = 0x44, wr_en pulsed for one edge, then sel = 0 -> reg_val_q = 0x44, src_alu_q = 1 and wr_seen_q = 1 after the edge, and they hold while wr_en = 0.
- Assert reset_n low between clock edges after a write -> reg_val_q = 0, src_alu_q = 0 and wr_seen_q = 0 immediately, while reg_val still tracks its inputs.
- With SEL_REG_WR_PARITY_EN, reg_val = 0xF3 -> reg_par = 0; reg_val = 0x44 -> reg_par = 0; reg_val = 0x01 -> reg_par = 1.

Source files
------------

// File: rtl/sel_reg_wr_alu_decoder_pkg.sv
// Shared constants for the register-file write-data source selector.
package sel_reg_wr_alu_decoder_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam logic SRC_DECODER = 1'b0;
  localparam logic SRC_ALU     = 1'b1;

endpackage

// File: rtl/sel_reg_wr_mux.sv
// Parameterized 2:1 combinational mux choosing between ALU result and decoder literal.
module sel_reg_wr_mux
  import sel_reg_wr_alu_decoder_pkg::*;
#(
  parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH
) (
  input  logic                 sel,
  input  logic [DataWidth-1:0] alu_val,
  input  logic [DataWidth-1:0] dec_val,
  output logic [DataWidth-1:0] out_val
);

  always_comb begin
    out_val = dec_val;
    if (sel == SRC_ALU) begin
      out_val = alu_val;
    end
  end

endmodule

// File: rtl/sel_reg_wr_alu_decoder.sv
// Register-file write-data selector with zero flag and capture of the last committed write.
// Optional even-parity output enabled by defining SEL_REG_WR_PARITY_EN.
module sel_reg_wr_alu_decoder
  import sel_reg_wr_alu_decoder_pkg::*;
#(
  parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DataWidth-1:0] literal_adr,
  input  logic [DataWidth-1:0] result,
  input  logic                 sel_reg_in_alu_decoder,
  input  logic                 wr_en,
  output logic [DataWidth-1:0] reg_val,
  output logic                 reg_zero,
  output logic [DataWidth-1:0] reg_val_q,
  output logic                 src_alu_q,
`ifdef SEL_REG_WR_PARITY_EN
  output logic                 reg_par,
`endif
  output logic                 wr_seen_q
);

  sel_reg_wr_mux #(
    .DataWidth(DataWidth)
  ) u_mux (
    .sel    (sel_reg_in_alu_decoder),
    .alu_val(result),
    .dec_val(literal_adr),
    .out_val(reg_val)
  );

  assign reg_zero = (reg_val == '0);

`ifdef SEL_REG_WR_PARITY_EN
  assign reg_par = ^reg_val;
`endif

  // Capture the value selected at the edge; reset always overrides a pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_val_q <= '0;
      src_alu_q <= SRC_DECODER;
      wr_seen_q <= 1'b0;
    end else if (wr_en) begin
      reg_val_q <= reg_val;
      src_alu_q <= sel_reg_in_alu_decoder;
      wr_seen_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sel_reg_wr_alu_decoder.sv
// Directed self-checking bench for sel_reg_wr_alu_decoder.
module tb_sel_reg_wr_alu_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] literal_adr;
  logic [7:0] result;
  logic       sel;
  logic       wr_en;
  logic [7:0] reg_val;
  logic       reg_zero;
  logic [7:0] reg_val_q;
  logic       src_alu_q;
  logic       wr_seen_q;
`ifdef SEL_REG_WR_PARITY_EN
  logic       reg_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sel_reg_wr_alu_decoder #(
    .DataWidth(8)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .literal_adr           (literal_adr),
    .result                (result),
    .sel_reg_in_alu_decoder(sel),
    .wr_en                 (wr_en),
    .reg_val               (reg_val),
    .reg_zero              (reg_zero),
    .reg_val_q             (reg_val_q),
    .src_alu_q             (src_alu_q),
`ifdef SEL_REG_WR_PARITY_EN
    .reg_par               (reg_par),
`endif
    .wr_seen_q             (wr_seen_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; sel = 1'b0; literal_adr = 8'h00; result = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (reg_val_q !== 8'h00) begin n_fail++; $display("FAIL reset_val_q got %h want 00", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b0) begin n_fail++; $display("FAIL reset_src got %b want 0", src_alu_q); end
    n_checks++; if (wr_seen_q !== 1'b0) begin n_fail++; $display("FAIL reset_seen got %b want 0", wr_seen_q); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_comb_select();
    sel = 1'b1; literal_adr = 8'h00; result = 8'h00;
    #1;
    n_checks++; if (reg_val !== 8'h00) begin n_fail++; $display("FAIL comb_zero_val got %h want 00", reg_val); end
    n_checks++; if (reg_zero !== 1'b1) begin n_fail++; $display("FAIL comb_zero_flag got %b want 1", reg_zero); end
    result = 8'h44;
    #1;
    n_checks++; if (reg_val !== 8'h44) begin n_fail++; $display("FAIL comb_alu_val got %h want 44", reg_val); end
    n_checks++; if (reg_zero !== 1'b0) begin n_fail++; $display("FAIL comb_alu_flag got %b want 0", reg_zero); end
    sel = 1'b0; literal_adr = 8'hF3; result = 8'h00;
    #1;
    n_checks++; if (reg_val !== 8'hF3) begin n_fail++; $display("FAIL comb_dec_val got %h want f3", reg_val); end
    n_checks++; if (reg_zero !== 1'b0) begin n_fail++; $display("FAIL comb_dec_flag got %b want 0", reg_zero); end
    literal_adr = 8'h00; result = 8'hFF;
    #1;
    n_checks++; if (reg_zero !== 1'b1) begin n_fail++; $display("FAIL comb_dec_zero got %b want 1", reg_zero); end
  endtask

  task automatic test_capture_hold();
    @(negedge clk);
    sel = 1'b1; result = 8'h44; literal_adr = 8'h00; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; sel = 1'b0; literal_adr = 8'h12;
    n_checks++; if (reg_val_q !== 8'h44) begin n_fail++; $display("FAIL cap_val got %h want 44", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b1) begin n_fail++; $display("FAIL cap_src got %b want 1", src_alu_q); end
    n_checks++; if (wr_seen_q !== 1'b1) begin n_fail++; $display("FAIL cap_seen got %b want 1", wr_seen_q); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (reg_val_q !== 8'h44) begin n_fail++; $display("FAIL hold_val got %h want 44", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b1) begin n_fail++; $display("FAIL hold_src got %b want 1", src_alu_q); end
    n_checks++; if (reg_val !== 8'h12) begin n_fail++; $display("FAIL hold_comb got %h want 12", reg_val); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    sel = 1'b0; literal_adr = 8'h5A; result = 8'hA5; wr_en = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (reg_val_q !== 8'h5A) begin n_fail++; $display("FAIL b2b_dec_val got %h want 5a", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b0) begin n_fail++; $display("FAIL b2b_dec_src got %b want 0", src_alu_q); end
    @(negedge clk);
    sel = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (reg_val_q !== 8'hA5) begin n_fail++; $display("FAIL b2b_alu_val got %h want a5", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b1) begin n_fail++; $display("FAIL b2b_alu_src got %b want 1", src_alu_q); end
    // Switch source late in the cycle; the edge must see the final selection.
    @(negedge clk);
    sel = 1'b0; literal_adr = 8'h33;
    #2;
    sel = 1'b1; result = 8'h77;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    n_checks++; if (reg_val_q !== 8'h77) begin n_fail++; $display("FAIL late_sw_val got %h want 77", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b1) begin n_fail++; $display("FAIL late_sw_src got %b want 1", src_alu_q); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (reg_val_q !== 8'h00) begin n_fail++; $display("FAIL arst_val got %h want 00", reg_val_q); end
    n_checks++; if (src_alu_q !== 1'b0) begin n_fail++; $display("FAIL arst_src got %b want 0", src_alu_q); end
    n_checks++; if (wr_seen_q !== 1'b0) begin n_fail++; $display("FAIL arst_seen got %b want 0", wr_seen_q); end
    sel = 1'b0; literal_adr = 8'hC8;
    #1;
    n_checks++; if (reg_val !== 8'hC8) begin n_fail++; $display("FAIL arst_comb got %h want c8", reg_val); end
    // Release with a write pending: first edge after release must capture.
    @(negedge clk);
    reset_n = 1'b1; sel = 1'b0; literal_adr = 8'h0F; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    n_checks++; if (reg_val_q !== 8'h0F) begin n_fail++; $display("FAIL first_cap_val got %h want 0f", reg_val_q); end
    n_checks++; if (wr_seen_q !== 1'b1) begin n_fail++; $display("FAIL first_cap_seen got %b want 1", wr_seen_q); end
  endtask

  task automatic test_reset_wins();
    @(negedge clk);
    sel = 1'b1; result = 8'h99; wr_en = 1'b1;
    #3;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (reg_val_q !== 8'h00) begin n_fail++; $display("FAIL rst_wins_val got %h want 00", reg_val_q); end
    n_checks++; if (wr_seen_q !== 1'b0) begin n_fail++; $display("FAIL rst_wins_seen got %b want 0", wr_seen_q); end
    wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (wr_seen_q !== 1'b0) begin n_fail++; $display("FAIL no_wr_seen got %b want 0", wr_seen_q); end
  endtask

`ifdef SEL_REG_WR_PARITY_EN
  task automatic test_parity();
    sel = 1'b0; literal_adr = 8'hF3;
    #1;
    n_checks++; if (reg_par !== 1'b0) begin n_fail++; $display("FAIL par_f3 got %b want 0", reg_par); end
    sel = 1'b1; result = 8'h44;
    #1;
    n_checks++; if (reg_par !== 1'b0) begin n_fail++; $display("FAIL par_44 got %b want 0", reg_par); end
    result = 8'h01;
    #1;
    n_checks++; if (reg_par !== 1'b1) begin n_fail++; $display("FAIL par_01 got %b want 1", reg_par); end
  endtask
`endif

  initial begin
    test_reset();
    test_comb_select();
    test_capture_hold();
    test_back_to_back();
    test_async_reset();
    test_reset_wins();
`ifdef SEL_REG_WR_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
